// File: rtl/dff_pipeline_if.sv
// -----------------------------------------------------------------------------
// dff_pipeline_if
// Bus bundle for the dff_pipeline delay line.
//   master : producer side; drives en, clr, d, d_valid; observes the outputs.
//   slave  : pipeline side; samples the controls and drives
//            q, q_valid, taps, fill_cnt, full.
// clk and rstn are not part of the bundle; they stay plain module ports.
// -----------------------------------------------------------------------------
interface dff_pipeline_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                   en;
  logic                   clr;
  logic [WIDTH-1:0]       d;
  logic                   d_valid;
  logic [WIDTH-1:0]       q;
  logic                   q_valid;
  logic [DEPTH*WIDTH-1:0] taps;
  logic [CNT_W-1:0]       fill_cnt;
  logic                   full;

  modport master (
    output en, clr, d, d_valid,
    input  q, q_valid, taps, fill_cnt, full
  );

  modport slave (
    input  en, clr, d, d_valid,
    output q, q_valid, taps, fill_cnt, full
  );
endinterface

// File: rtl/dff_pipeline.sv
// -----------------------------------------------------------------------------
// dff_pipeline
// WIDTH-bit, DEPTH-stage register pipeline with per-stage valid bits, shift
// enable (stall), synchronous flush, fill counter and full flag.
// Ports:
//   clk   : rising-edge clock
//   rstn  : synchronous active-low reset
//   bus   : dff_pipeline_if.slave
//           en       shift enable (0 = hold everything)
//           clr      synchronous flush, same effect as reset
//           d        data into stage 0, d_valid qualifies it
//           q        stage DEPTH-1 data, q_valid its valid bit
//           taps     all stages, stage i at [i*WIDTH +: WIDTH]
//           fill_cnt number of valid stages (0..DEPTH)
//           full     fill_cnt == DEPTH
// Every output comes straight from a register.
// -----------------------------------------------------------------------------
module dff_pipeline #(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic           clk,
  input  logic           rstn,
  dff_pipeline_if.slave  bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [CNT_W-1:0] fill_q;
  logic [CNT_W-1:0] fill_d;
  logic             full_q;
  logic             full_d;

  // Next-state: clear beats shift beats hold (reset handled in the flop block).
  always_comb begin
    stage_d = stage_q;
    valid_d = valid_q;
    fill_d  = fill_q;
    full_d  = full_q;
    if (bus.clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_d[i] = RST_VAL;
      end
      valid_d = '0;
      fill_d  = '0;
      full_d  = 1'b0;
    end else if (bus.en) begin
      stage_d[0] = bus.d;
      valid_d[0] = bus.d_valid;
      for (int i = DEPTH - 1; i >= 1; i--) begin
        stage_d[i] = stage_q[i-1];
        valid_d[i] = valid_q[i-1];
      end
      // Entry and exit are tracked incrementally; the oldest valid bit is the
      // one leaving on this edge, so the count stays within 0..DEPTH.
      fill_d = fill_q + CNT_W'(bus.d_valid) - CNT_W'(valid_q[DEPTH-1]);
      full_d = (fill_d == CNT_W'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= RST_VAL;
      end
      valid_q <= '0;
      fill_q  <= '0;
      full_q  <= 1'b0;
    end else begin
      stage_q <= stage_d;
      valid_q <= valid_d;
      fill_q  <= fill_d;
      full_q  <= full_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_taps
      assign bus.taps[gi*WIDTH +: WIDTH] = stage_q[gi];
    end
  endgenerate

  assign bus.q        = stage_q[DEPTH-1];
  assign bus.q_valid  = valid_q[DEPTH-1];
  assign bus.fill_cnt = fill_q;
  assign bus.full     = full_q;
endmodule

// File: tb/tb_dff_pipeline.sv
// -----------------------------------------------------------------------------
// tb_dff_pipeline
// Directed bench for dff_pipeline: an 8x4 instance checked against a history
// model plus a queue of valid data, and a 1x1 instance checked as a plain
// enabled D flip-flop with valid.
// -----------------------------------------------------------------------------
module tb_dff_pipeline;
  localparam int W = 8;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rstn;
  logic rstn1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dff_pipeline_if #(.WIDTH(W), .DEPTH(D)) bus0 ();
  dff_pipeline_if #(.WIDTH(1), .DEPTH(1)) bus1 ();

  dff_pipeline #(.WIDTH(W), .DEPTH(D), .RST_VAL(8'h00)) dut0 (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus0)
  );

  dff_pipeline #(.WIDTH(1), .DEPTH(1), .RST_VAL(1'b0)) dut1 (
    .clk  (clk),
    .rstn (rstn1),
    .bus  (bus1)
  );

  typedef struct {
    logic [W-1:0] data;
    logic         v;
  } ent_t;

  ent_t         hist[$];   // every captured entry, newest at the back
  logic [W-1:0] sb[$];     // valid data awaiting exit on q
  int           fill_peak;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One edge on the 8x4 instance; updates the model and compares everything.
  task automatic tick(input logic r, input logic c, input logic e,
                      input logic [W-1:0] dd, input logic dv);
    logic [W-1:0]     exp_q;
    logic             exp_qv;
    int               exp_fill;
    logic [D*W-1:0]   exp_taps;
    logic [W-1:0]     front;
    int               idx;
    logic             shifted;
    rstn = r; bus0.clr = c; bus0.en = e; bus0.d = dd; bus0.d_valid = dv;
    @(posedge clk);
    #1;
    shifted = 1'b0;
    if (!r || c) begin
      hist.delete();
      sb.delete();
    end else if (e) begin
      shifted = 1'b1;
      hist.push_back('{data: dd, v: dv});
      if (hist.size() > D) void'(hist.pop_front());
      if (dv) sb.push_back(dd);
    end
    exp_q  = 8'h00;
    exp_qv = 1'b0;
    if (hist.size() == D) begin
      exp_q  = hist[0].data;
      exp_qv = hist[0].v;
    end
    exp_fill = 0;
    foreach (hist[k]) if (hist[k].v) exp_fill++;
    exp_taps = '0;
    for (int i = 0; i < D; i++) begin
      idx = hist.size() - 1 - i;
      if (idx >= 0) exp_taps[i*W +: W] = hist[idx].data;
    end
    chk("q", 64'(bus0.q), 64'(exp_q));
    chk("q_valid", 64'(bus0.q_valid), 64'(exp_qv));
    chk("fill_cnt", 64'(bus0.fill_cnt), 64'(exp_fill));
    chk("full", 64'(bus0.full), 64'(exp_fill == D));
    chk("taps", 64'(bus0.taps), 64'(exp_taps));
    if (shifted && bus0.q_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 64'(sb.size()), 64'd1);
      end else begin
        front = sb.pop_front();
        chk("sb_q", 64'(bus0.q), 64'(front));
      end
    end
    if (int'(bus0.fill_cnt) > fill_peak) fill_peak = int'(bus0.fill_cnt);
  endtask

  // One edge on the 1x1 instance: q must be d delayed by one enabled edge.
  task automatic tick1(input logic r, input logic e, input logic dd, input logic dv,
                       input logic exp_q, input logic exp_v);
    rstn1 = r; bus1.clr = 1'b0; bus1.en = e; bus1.d = dd; bus1.d_valid = dv;
    @(posedge clk);
    #1;
    chk("d1_q", 64'(bus1.q), 64'(exp_q));
    chk("d1_q_valid", 64'(bus1.q_valid), 64'(exp_v));
    chk("d1_fill_cnt", 64'(bus1.fill_cnt), 64'(exp_v));
    chk("d1_full", 64'(bus1.full), 64'(exp_v));
  endtask

  initial begin
    logic [W-1:0] seq_d [4];
    logic         seq_v [4];

    rstn = 1'b0; bus0.clr = 1'b0; bus0.en = 1'b1; bus0.d = 8'hFF; bus0.d_valid = 1'b1;
    rstn1 = 1'b0; bus1.clr = 1'b0; bus1.en = 1'b0; bus1.d = 1'b0; bus1.d_valid = 1'b0;
    fill_peak = 0;

    // Reset with traffic present
    tick(1'b0, 1'b0, 1'b1, 8'hFF, 1'b1);
    tick(1'b0, 1'b0, 1'b1, 8'hFF, 1'b1);
    chk("rst_taps", 64'(bus0.taps), 64'h0);
    chk("rst_q", 64'(bus0.q), 64'h0);

    // Latency and fill
    tick(1'b1, 1'b0, 1'b1, 8'h11, 1'b1);
    chk("lat_fill1", 64'(bus0.fill_cnt), 64'd1);
    tick(1'b1, 1'b0, 1'b1, 8'h22, 1'b1);
    chk("lat_fill2", 64'(bus0.fill_cnt), 64'd2);
    tick(1'b1, 1'b0, 1'b1, 8'h33, 1'b1);
    chk("lat_q_early", 64'(bus0.q_valid), 64'd0);
    tick(1'b1, 1'b0, 1'b1, 8'h44, 1'b1);
    chk("lat_q", 64'(bus0.q), 64'h11);
    chk("lat_qv", 64'(bus0.q_valid), 64'd1);
    chk("lat_full", 64'(bus0.full), 64'd1);
    tick(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
    chk("lat_fill3", 64'(bus0.fill_cnt), 64'd3);
    chk("lat_q22", 64'(bus0.q), 64'h22);

    // Stall on a full pipeline
    tick(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    tick(1'b1, 1'b0, 1'b1, 8'h11, 1'b1);
    tick(1'b1, 1'b0, 1'b1, 8'h22, 1'b1);
    tick(1'b1, 1'b0, 1'b1, 8'h33, 1'b1);
    tick(1'b1, 1'b0, 1'b1, 8'h44, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0, 1'b0, (i % 2 == 0) ? 8'hAA : 8'h5A, i[0]);
      chk("stall_taps", 64'(bus0.taps), 64'h11223344);
      chk("stall_q", 64'(bus0.q), 64'h11);
      chk("stall_fill", 64'(bus0.fill_cnt), 64'd4);
      chk("stall_full", 64'(bus0.full), 64'd1);
    end
    tick(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
    chk("resume_q", 64'(bus0.q), 64'h22);

    // Bubbles
    tick(1'b1, 1'b1, 1'b1, 8'h00, 1'b0);
    fill_peak = 0;
    seq_d[0] = 8'hA0; seq_d[1] = 8'hA1; seq_d[2] = 8'hA2; seq_d[3] = 8'hA3;
    seq_v[0] = 1'b1;  seq_v[1] = 1'b0;  seq_v[2] = 1'b1;  seq_v[3] = 1'b0;
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b1, seq_d[i], seq_v[i]);
    chk("bub_q0", 64'(bus0.q), 64'(seq_d[0]));
    chk("bub_v0", 64'(bus0.q_valid), 64'(seq_v[0]));
    for (int i = 1; i < 4; i++) begin
      tick(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
      chk("bub_q", 64'(bus0.q), 64'(seq_d[i]));
      chk("bub_v", 64'(bus0.q_valid), 64'(seq_v[i]));
    end
    chk("bub_peak", 64'(fill_peak), 64'd2);

    // Flush against simultaneous traffic
    tick(1'b1, 1'b0, 1'b1, 8'h01, 1'b1);
    tick(1'b1, 1'b0, 1'b1, 8'h02, 1'b1);
    tick(1'b1, 1'b0, 1'b1, 8'h03, 1'b1);
    tick(1'b1, 1'b0, 1'b1, 8'h04, 1'b1);
    chk("pre_flush_full", 64'(bus0.full), 64'd1);
    tick(1'b1, 1'b1, 1'b1, 8'h55, 1'b1);
    chk("flush_taps", 64'(bus0.taps), 64'h0);
    chk("flush_fill", 64'(bus0.fill_cnt), 64'd0);
    chk("flush_full", 64'(bus0.full), 64'd0);

    // Reset mid-stream wins over en
    tick(1'b1, 1'b0, 1'b1, 8'h66, 1'b1);
    tick(1'b1, 1'b0, 1'b1, 8'h67, 1'b1);
    tick(1'b0, 1'b0, 1'b1, 8'h77, 1'b1);
    chk("midrst_taps", 64'(bus0.taps), 64'h0);
    chk("midrst_fill", 64'(bus0.fill_cnt), 64'd0);
    tick(1'b1, 1'b0, 1'b1, 8'h78, 1'b1);

    // Hold the big instance and exercise DEPTH=1, WIDTH=1
    rstn = 1'b1; bus0.en = 1'b0;
    tick1(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    tick1(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    tick1(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick1(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    tick1(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick1(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    tick1(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    tick1(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
